// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the fetch/load-store memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory signals of the arbiter; slave is the arbiter's view,
// master is the core/memory side.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// one access at a time, data-first with a bounded starvation streak for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_LD  = LAT_W'(MEM_LAT);

  state_t            r_state;
  owner_t            r_owner;
  logic [LAT_W-1:0]  r_lat;
  logic [ST_W-1:0]   r_streak;

  logic              r_if_gnt;
  logic              r_if_done;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_gnt;
  logic              r_d_done;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_pick_d;
  logic [ST_W-1:0]   w_streak_inc;

  // Data wins ties unless fetch has already lost STARVE_MAX times in a row.
  assign w_pick_d     = bus.d_req && !(bus.if_req && (r_streak == ST_MAX));
  assign w_streak_inc = (r_streak == ST_MAX) ? r_streak : r_streak + ST_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_lat       <= '0;
      r_streak    <= '0;
      r_if_gnt    <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_gnt     <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_gnt  <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_mem_en  <= 1'b0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_owner     <= OWN_D;
            r_d_gnt     <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_streak    <= bus.if_req ? w_streak_inc : '0;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end else if (bus.if_req) begin
            r_owner     <= OWN_IF;
            r_if_gnt    <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_streak    <= '0;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_lat   <= LAT_LD;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_lat == LAT_W'(1)) begin
            if (r_owner == OWN_D) begin
              r_d_done  <= 1'b1;
              r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
            end else begin
              r_if_done  <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end
            r_state <= RESP;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.if_done   = r_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_gnt     = r_d_gnt;
  assign bus.d_done    = r_d_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected
// grant/done events; a negedge monitor pops and compares each observed event.
module tb_mem_port_arbiter;

  localparam logic [4:0] EV_IG = 5'b11000;  // {mem_en, if_gnt, d_gnt, if_done, d_done}
  localparam logic [4:0] EV_DG = 5'b10100;
  localparam logic [4:0] EV_ID = 5'b00010;
  localparam logic [4:0] EV_DD = 5'b00001;

  typedef struct {
    logic [4:0]  code;
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  exp_t        exp_q[$];
  logic [31:0] if_q[$];
  dreq_t       d_q[$];

  logic [31:0] wmem [0:255];
  bit          written [0:255];
  int          pend_cyc = -1;
  logic [31:0] pend_d;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_LAT   (2),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2002_0005;
      32'h0000_0044: return 32'h0000_0013;
      32'h0000_0048: return 32'h0040_0093;
      32'h0000_0080: return 32'h1234_5678;
      default:       return 32'hBAD0_0000 ^ a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [4:0] code, input int c, input logic we,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] d);
    exp_t e;
    e.code = code; e.cyc = c; e.we = we; e.addr = a; e.wdata = wd; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    dreq_t r;
    r.we = we; r.addr = a; r.wdata = wd;
    d_q.push_back(r);
  endtask

  // Returns 2 time units after the first rising edge at which cyc >= c.
  task automatic wait_until(input int c);
    forever begin
      @(posedge clk);
      #2;
      if (cyc >= c) break;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.if_gnt, bus.if_done, bus.d_gnt, bus.d_done,
                           bus.mem_en, bus.mem_we, bus.busy}), 64'd0);
    chk({tag, "_rdata"}, {bus.if_rdata, bus.d_rdata}, 64'd0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 64'd0);
  endtask

  // Memory: read data valid exactly MEM_LAT cycles after the mem_en cycle.
  initial forever begin
    @(posedge clk);
    #1;
    bus.mem_rdata = (cyc == pend_cyc) ? pend_d : 32'hBAD0_BAD0;
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        wmem[bus.mem_addr[9:2]]    = bus.mem_wdata;
        written[bus.mem_addr[9:2]] = 1'b1;
      end else begin
        pend_cyc = cyc + 2;
        pend_d   = written[bus.mem_addr[9:2]] ? wmem[bus.mem_addr[9:2]]
                                              : init_val(bus.mem_addr);
      end
    end
  end

  // Requesters: hold req until the cycle after gnt, then move to the next queued access.
  initial begin
    bit if_g_prev = 1'b0;
    bit d_g_prev  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (if_g_prev && if_q.size() > 0) void'(if_q.pop_front());
      if (d_g_prev && d_q.size() > 0) void'(d_q.pop_front());
      if_g_prev = (bus.if_gnt === 1'b1);
      d_g_prev  = (bus.d_gnt === 1'b1);
      bus.if_req = (if_q.size() > 0);
      if (if_q.size() > 0) bus.if_addr = if_q[0];
      bus.d_req = (d_q.size() > 0);
      if (d_q.size() > 0) begin
        bus.d_we    = d_q[0].we;
        bus.d_addr  = d_q[0].addr;
        bus.d_wdata = d_q[0].wdata;
      end
    end
  end

  // Monitor
  initial forever begin
    logic [4:0] obs;
    exp_t       e;
    @(negedge clk);
    obs = {bus.mem_en, bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done};
    if (cyc > 0 && obs != 5'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp  = n_cmp + 1;
        n_fail = n_fail + 1;
        $display("FAIL unexpected_event: got code %b at cycle %0d, required none", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_code", 64'(obs), 64'(e.code));
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        if (e.code == EV_IG || e.code == EV_DG) begin
          chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
          chk("mem_we", 64'(bus.mem_we), 64'(e.we));
          if (e.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
        end else if (e.code == EV_ID) begin
          chk("if_rdata", 64'(bus.if_rdata), 64'(e.data));
        end else begin
          chk("d_rdata", 64'(bus.d_rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    int s;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;

    // Reset with both requesters already asserted; sampled in cycle 2.
    if_q.push_back(32'h0000_0040);
    push_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    push_exp(EV_DG, 3, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, '0);
    push_exp(EV_DD, 6, 1'b0, '0, '0, 32'h0);
    push_exp(EV_IG, 8, 1'b0, 32'h0000_0040, '0, '0);
    push_exp(EV_ID, 11, 1'b0, '0, '0, 32'h2002_0005);
    @(negedge clk);
    chk_all_zero("reset_c1");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_c2");

    wait_until(11);
    @(negedge clk);
    chk("busy_resp", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("busy_idle", 64'(bus.busy), 64'd0);

    // Load back the stored word.
    wait_until(13);
    s = cyc + 1;
    push_d(1'b0, 32'h0000_0100, 32'h0);
    push_exp(EV_DG, s + 1, 1'b0, 32'h0000_0100, '0, '0);
    push_exp(EV_DD, s + 4, 1'b0, '0, '0, 32'hDEAD_BEEF);

    // Lone fetch.
    wait_until(s + 5);
    s = cyc + 1;
    if_q.push_back(32'h0000_0044);
    push_exp(EV_IG, s + 1, 1'b0, 32'h0000_0044, '0, '0);
    push_exp(EV_ID, s + 4, 1'b0, '0, '0, 32'h0000_0013);

    // Starvation: fetch waits behind four data grants, then wins the fifth slot.
    wait_until(s + 5);
    s = cyc + 1;
    if_q.push_back(32'h0000_0048);
    for (int k = 0; k < 5; k++) push_d(1'b1, 32'h0000_0200 + 32'(4 * k), 32'hA000_0000 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      push_exp(EV_DG, s + 1 + 5 * k, 1'b1, 32'h0000_0200 + 32'(4 * k), 32'hA000_0000 + 32'(k), '0);
      push_exp(EV_DD, s + 4 + 5 * k, 1'b0, '0, '0, 32'h0);
    end
    push_exp(EV_IG, s + 21, 1'b0, 32'h0000_0048, '0, '0);
    push_exp(EV_ID, s + 24, 1'b0, '0, '0, 32'h0040_0093);
    push_exp(EV_DG, s + 26, 1'b1, 32'h0000_0210, 32'hA000_0004, '0);
    push_exp(EV_DD, s + 29, 1'b0, '0, '0, 32'h0);

    // Reset during the first WAIT cycle of a fetch: no done may follow.
    wait_until(s + 30);
    s = cyc + 1;
    if_q.push_back(32'h0000_0080);
    push_exp(EV_IG, s + 1, 1'b0, 32'h0000_0080, '0, '0);
    wait_until(s + 2);
    rst = 1'b1;
    wait_until(s + 3);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("midop_reset");

    wait_until(s + 8);
    s = cyc + 1;
    if_q.push_back(32'h0000_0080);
    push_exp(EV_IG, s + 1, 1'b0, 32'h0000_0080, '0, '0);
    push_exp(EV_ID, s + 4, 1'b0, '0, '0, 32'h1234_5678);

    wait_until(s + 10);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the core's instruction-fetch requester and its load/store requester.
- Accepts one request at a time and issues exactly one memory access.
- Waits a fixed memory latency, then returns read data or write completion to the winning requester.
- Sits between the sequential core and the memory, replacing the core's separate instruction and data memory ports.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; must be at least 1.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_done  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_done  out  1  one-cycle pulse: read data valid, or write complete.
- d_rdata  out  DATA_W  load data; 0 on write completion.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- On rst:
  - state goes to IDLE and the streak counter to 0.
  - All outputs go to 0 on the next edge.
  - Any in-flight access is abandoned: no done pulse is produced and later mem_rdata is ignored.
- All outputs are registered.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: requests are sampled only here. If no request, stay in IDLE. Otherwise pick an owner, latch its address/we/wdata, and go to ISSUE.
  - ISSUE (1 cycle): the owner's gnt pulses and mem_en pulses; mem_we/mem_addr/mem_wdata are driven. Load the latency counter with MEM_LAT.
  - WAIT (MEM_LAT cycles): mem_en=0; mem_addr/mem_we/mem_wdata hold. On the last WAIT cycle, capture mem_rdata (0 if the access is a write).
  - RESP (1 cycle): the owner's done pulses with rdata; the other requester's done stays 0. Then return to IDLE.
- Timing: a request sampled in cycle N gives gnt at N+1 and done at N+2+MEM_LAT; next arbitration is at N+3+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Priority:
  - The data requester wins when both request, unless streak == STARVE_MAX, in which case fetch wins.
  - streak increments on a data grant while if_req=1.
  - streak clears on any fetch grant, and on a data grant while if_req=0.
  - streak saturates at STARVE_MAX.
- Handshake rules:
  - A requester deasserts req in the cycle after gnt unless it wants another access.
  - A req still high when the arbiter returns to IDLE is treated as a new request.
- if_rdata/d_rdata hold their last value between done pulses; they are only meaningful with done.
- Only one of if_gnt/d_gnt, and only one of if_done/d_done, may be high in any cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - owner_t enum {OWN_IF, OWN_D}.
  - Default ADDR_W/DATA_W constants.
- Latency counter width is $clog2(MEM_LAT+1); streak counter width is $clog2(STARVE_MAX+1).
- No sub-module: the priority pick is a few lines inside the FSM.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Reset: rst=1 for 2 cycles with if_req=d_req=1 -> all outputs 0 and busy=0 throughout; first grant comes 2 cycles after rst falls (sample edge, then ISSUE).
- Fetch: if_req with if_addr=0x0000_0040 sampled at N; memory returns 0x2002_0005 -> if_gnt and mem_en at N+1 with mem_addr=0x40, mem_we=0; if_done=1 and if_rdata=0x2002_0005 at N+4; busy low at N+5.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF at N -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF at N+1; d_done=1 with d_rdata=0 at N+4.
- Simultaneous requests: if_req and d_req both rise at N -> d_gnt at N+1, d_done at N+4; if_gnt at N+6, if_done at N+9.
- Starvation: if_req held and d_req re-asserted continuously -> 4 data grants, then the 5th grant is if_gnt; streak returns to 0.
- Reset mid-op: rst=1 in the first WAIT cycle of a read -> outputs 0 next cycle, no if_done/d_done; a fresh fetch after reset completes with the correct data.
